// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared defaults, pattern encoding and colour helpers for the VGA pattern generator
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int BOX_SIZE_DEF = 32;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_GRAD  = 2'd3
  } pattern_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '0;
  localparam rgb_t RGB_WHITE = '1;

  // Bar order white, yellow, cyan, green, magenta, red, blue, black.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c.r = {8{~idx[1]}};
    c.g = {8{~idx[2]}};
    c.b = {8{~idx[0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - timing input and pixel output bundle of the pattern generator
interface vga_pattern_gen_if;

  logic        h_sync_in;
  logic        v_sync_in;
  logic [10:0] horizontal_position_in;
  logic [9:0]  vertical_position_in;

  logic        h_sync_out;
  logic        v_sync_out;
  logic        blank_n_out;
  logic [7:0]  red_out;
  logic [7:0]  green_out;
  logic [7:0]  blue_out;
  logic        frame_start_out;

  modport master (
    output h_sync_in, v_sync_in, horizontal_position_in, vertical_position_in,
    input  h_sync_out, v_sync_out, blank_n_out, red_out, green_out, blue_out, frame_start_out
  );

  modport slave (
    input  h_sync_in, v_sync_in, horizontal_position_in, vertical_position_in,
    output h_sync_out, v_sync_out, blank_n_out, red_out, green_out, blue_out, frame_start_out
  );

endinterface

// File: rtl/vga_box_animator.sv
// rtl/vga_box_animator.sv - bouncing box position, advanced one pixel per enabled frame boundary
module vga_box_animator
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [10:0] box_x,
  output logic [9:0]  box_y
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - BOX_SIZE);

  // Direction bit: 0 = moving positive, 1 = moving negative.
  logic        dir_x, dir_y;
  logic        dir_x_next, dir_y_next;
  logic [10:0] x_next;
  logic [9:0]  y_next;

  // A flip at an edge still takes the step, now in the new direction.
  always_comb begin
    dir_x_next = dir_x ^ (dir_x ? (box_x == 11'd0) : (box_x == X_MAX));
    dir_y_next = dir_y ^ (dir_y ? (box_y == 10'd0) : (box_y == Y_MAX));
    x_next     = dir_x_next ? box_x - 11'd1 : box_x + 11'd1;
    y_next     = dir_y_next ? box_y - 10'd1 : box_y + 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b0;
      dir_y <= 1'b0;
    end else if (step) begin
      box_x <= x_next;
      box_y <= y_next;
      dir_x <= dir_x_next;
      dir_y <= dir_y_next;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage test pattern generator with bouncing white box overlay
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BOX_SIZE = BOX_SIZE_DEF
) (
  input  logic              vga_clk_in,
  input  logic              reset_in,
  input  logic [1:0]        pattern_sel_in,
  input  logic              box_en_in,
  vga_pattern_gen_if.slave  vid
);

  logic        boundary;
  pattern_t    pat_q;
  logic [10:0] box_x;
  logic [9:0]  box_y;

  logic [10:0] h1;
  logic [9:0]  v1;
  logic        hs1, vs1, vis1, fs1, box_en1;

  logic        in_box;
  logic [2:0]  bar_idx;
  rgb_t        px;

  assign boundary = (vid.horizontal_position_in == 11'd0) &&
                    (vid.vertical_position_in == 10'(V_ACTIVE));

  // The boundary sample is never visible, so latching here cannot tear a frame.
  always_ff @(posedge vga_clk_in or negedge reset_in) begin
    if (!reset_in) pat_q <= PAT_BLACK;
    else if (boundary) pat_q <= pattern_t'(pattern_sel_in);
  end

  vga_box_animator #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE)
  ) u_box (
    .clk   (vga_clk_in),
    .rst_n (reset_in),
    .step  (boundary && box_en_in),
    .box_x (box_x),
    .box_y (box_y)
  );

  always_ff @(posedge vga_clk_in or negedge reset_in) begin
    if (!reset_in) begin
      h1      <= '0;
      v1      <= '0;
      hs1     <= 1'b1;
      vs1     <= 1'b1;
      vis1    <= 1'b0;
      fs1     <= 1'b0;
      box_en1 <= 1'b0;
    end else begin
      h1      <= vid.horizontal_position_in;
      v1      <= vid.vertical_position_in;
      hs1     <= vid.h_sync_in;
      vs1     <= vid.v_sync_in;
      vis1    <= (vid.horizontal_position_in < 11'(H_ACTIVE)) &&
                 (vid.vertical_position_in < 10'(V_ACTIVE));
      fs1     <= boundary;
      box_en1 <= box_en_in;
    end
  end

  assign in_box  = ({1'b0, h1} >= {1'b0, box_x}) &&
                   ({1'b0, h1} <  {1'b0, box_x} + 12'(BOX_SIZE)) &&
                   ({1'b0, v1} >= {1'b0, box_y}) &&
                   ({1'b0, v1} <  {1'b0, box_y} + 11'(BOX_SIZE));
  assign bar_idx = 3'(h1 / 11'(H_ACTIVE / 8));

  always_comb begin
    px = RGB_BLACK;
    if (vis1) begin
      if (box_en1 && in_box) begin
        px = RGB_WHITE;
      end else begin
        case (pat_q)
          PAT_BARS:  px = bar_colour(bar_idx);
          PAT_CHECK: px = (h1[5] ^ v1[5]) ? RGB_BLACK : RGB_WHITE;
          PAT_GRAD:  px = '{r: h1[7:0], g: v1[7:0], b: h1[9:2]};
          default:   px = RGB_BLACK;
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk_in or negedge reset_in) begin
    if (!reset_in) begin
      vid.h_sync_out      <= 1'b1;
      vid.v_sync_out      <= 1'b1;
      vid.blank_n_out     <= 1'b0;
      vid.red_out         <= '0;
      vid.green_out       <= '0;
      vid.blue_out        <= '0;
      vid.frame_start_out <= 1'b0;
    end else begin
      vid.h_sync_out      <= hs1;
      vid.v_sync_out      <= vs1;
      vid.blank_n_out     <= vis1;
      vid.red_out         <= px.r;
      vid.green_out       <= px.g;
      vid.blue_out        <= px.b;
      vid.frame_start_out <= fs1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed and randomized bench for vga_pattern_gen against a frame-level model
module tb_vga_pattern_gen;
  import vga_pkg::*;

  localparam int H = 640;
  localparam int V = 480;
  localparam int B = 32;
  localparam logic [27:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h000000, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       en = 1'b0;

  vga_pattern_gen_if vid ();

  vga_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .BOX_SIZE(B)) dut (
    .vga_clk_in     (clk),
    .reset_in       (rst_n),
    .pattern_sel_in (sel),
    .box_en_in      (en),
    .vid            (vid)
  );

  always #5 clk = ~clk;

  logic [27:0] obs;
  assign obs = {vid.h_sync_out, vid.v_sync_out, vid.blank_n_out, vid.red_out,
                vid.green_out, vid.blue_out, vid.frame_start_out};

  int          checks = 0;
  int          errors = 0;
  int          m_pat = 0;
  int          m_steps = 0;
  logic [27:0] q[$];
  string       tq[$];

  // Position after n enabled boundaries is a triangle wave of period 2*range.
  function automatic int tri_pos(int n, int range);
    int p = n % (2 * range);
    return (p <= range) ? p : 2 * range - p;
  endfunction

  function automatic logic [23:0] bar_rgb(int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [27:0] model_out(int h, int v, logic hs, logic vs, int pat, logic e, int n);
    logic [23:0] rgb = 24'h0;
    logic        vis = (h < H) && (v < V);
    int          bx = tri_pos(n, H - B);
    int          by = tri_pos(n, V - B);
    if (vis) begin
      if (e && h >= bx && h < bx + B && v >= by && v < by + B) rgb = 24'hFFFFFF;
      else begin
        case (pat)
          1: rgb = bar_rgb(h / (H / 8));
          2: rgb = ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
          3: rgb = {8'(h % 256), 8'(v % 256), 8'((h / 4) % 256)};
          default: rgb = 24'h0;
        endcase
      end
    end
    return {hs, vs, vis, rgb, (h == 0 && v == V)};
  endfunction

  task automatic check(string tag, logic [27:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(int h_in, int v_in, logic hs, logic vs, logic [1:0] s, logic e, string tag);
    int h = h_in & 2047;
    int v = v_in & 1023;
    @(negedge clk);
    check(tq.pop_front(), q.pop_front());
    vid.horizontal_position_in = 11'(h);
    vid.vertical_position_in   = 10'(v);
    vid.h_sync_in = hs;
    vid.v_sync_in = vs;
    sel = s;
    en  = e;
    q.push_back(model_out(h, v, hs, vs, m_pat, e, m_steps));
    tq.push_back(tag);
    if (h == 0 && v == V) begin
      m_pat = int'(s);
      if (e) m_steps++;
    end
  endtask

  task automatic do_reset(int cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    vid.horizontal_position_in = '0;
    vid.vertical_position_in   = '0;
    vid.h_sync_in = 1'b1;
    vid.v_sync_in = 1'b1;
    sel = 2'd0;
    en  = 1'b0;
    #1;
    check("reset_async", IDLE);
    repeat (cycles) begin
      @(negedge clk);
      check("reset_hold", IDLE);
    end
    m_pat = 0;
    m_steps = 0;
    q.delete();
    tq.delete();
    rst_n = 1'b1;
    q.push_back(IDLE);
    tq.push_back("post_reset_idle");
    q.push_back(model_out(0, 0, 1'b1, 1'b1, 0, 1'b0, 0));
    tq.push_back("post_reset_first");
  endtask

  task automatic box_probes(logic e);
    int bx = tri_pos(m_steps, H - B);
    int by = tri_pos(m_steps, V - B);
    step(bx, by, 1, 1, 0, e, "box_corner");
    step(bx - 1, by, 1, 1, 0, e, "box_left");
    step(bx + B - 1, by + B - 1, 1, 1, 0, e, "box_far");
    step(bx + B, by, 1, 1, 0, e, "box_right");
    step(bx, by + B, 1, 1, 0, e, "box_below");
    step(bx, by - 1, 1, 1, 0, e, "box_above");
  endtask

  initial begin
    vid.horizontal_position_in = '0;
    vid.vertical_position_in   = '0;
    vid.h_sync_in = 1'b1;
    vid.v_sync_in = 1'b1;

    do_reset(5);
    step(0, 0, 1, 1, 0, 0, "black_origin");
    step(1, 0, 1, 1, 0, 0, "black_next");

    step(0, V, 1, 0, 1, 0, "latch_bars");
    step(85, 10, 1, 1, 1, 0, "bars_h85");
    step(639, 10, 1, 1, 1, 0, "bars_h639");
    step(640, 10, 1, 1, 1, 0, "bars_h640");
    for (int i = 0; i < 8; i++) step(i * (H / 8) + 3, 20, 1, 1, 1, 0, "bars_sweep");

    step(0, V, 1, 0, 2, 0, "latch_check");
    step(32, 0, 1, 1, 2, 0, "check_32_0");
    step(32, 32, 1, 1, 2, 0, "check_32_32");
    step(31, 0, 0, 1, 2, 0, "check_31_0");
    step(100, 479, 1, 1, 2, 0, "check_last_line");
    step(0, 480, 1, 1, 1, 0, "latch_bars_again");

    step(85, 99, 1, 1, 1, 0, "midframe_pre");
    step(85, 100, 1, 1, 3, 0, "midframe_sel3");
    step(300, 200, 0, 1, 3, 0, "midframe_held");
    step(639, 479, 1, 1, 3, 0, "midframe_last");
    step(0, V, 1, 0, 3, 0, "frame_edge");
    step(1, V, 1, 0, 3, 0, "after_edge");
    step(85, 10, 1, 1, 3, 0, "grad_h85");
    step(517, 301, 1, 1, 3, 0, "grad_h517");

    step(5, 5, 1, 1, 3, 0, "hsync_hi");
    step(6, 5, 0, 1, 3, 0, "hsync_toggle");
    step(7, 5, 1, 0, 3, 0, "vsync_toggle");

    repeat (3000) begin
      int h = $urandom_range(0, 700);
      int v = $urandom_range(0, 520);
      if ($urandom_range(0, 19) == 0) begin
        h = 0;
        v = V;
      end else if ($urandom_range(0, 49) == 0) begin
        h = $urandom_range(0, 2047);
      end
      step(h, v, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), "random");
    end
    step(0, 0, 1, 1, 0, 0, "flush");
    step(0, 0, 1, 1, 0, 0, "flush");

    do_reset(2);
    repeat (607) step(0, V, 1, 0, 0, 1, "box_walk");
    box_probes(1);
    step(0, V, 1, 0, 0, 1, "box_step_608");
    box_probes(1);
    step(0, V, 1, 0, 0, 1, "box_step_607");
    box_probes(1);
    repeat (3) step(0, V, 1, 0, 0, 0, "box_frozen_frame");
    box_probes(1);
    box_probes(0);

    step(0, V, 1, 0, 2, 1, "latch_and_step");
    box_probes(1);
    step(200, 200, 1, 1, 2, 1, "pre_async_reset");
    do_reset(1);
    step(0, 0, 1, 1, 0, 0, "after_async");
    step(0, 0, 1, 1, 0, 0, "flush");
    step(0, 0, 1, 1, 0, 0, "flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
